// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way, 8-set branch target buffer.
// Optional same-cycle forwarding is enabled with the BTB_BYPASS_EN macro.
package btb_pkg;

    localparam int XLEN  = 32;
    localparam int SETS  = 8;
    localparam int IDX_W = 3;
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [1:0] CTR_RESET = 2'b01;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

    typedef enum logic {
        IDLE,
        COMMIT
    } btb_state_e;

    function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] pc);
        return pc[XLEN-1:IDX_W+2];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [XLEN-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating up/down counter next-value logic (00..11, never wraps).
module btb_sat_ctr (
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] next
);

    // Step toward the requested direction, holding at either end of the range.
    always_comb begin
        next = ctr;
        if (up) begin
            if (ctr != 2'b11) next = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/btb_core.sv
// Branch target buffer storage and control: combinational IF-stage lookup,
// EX-stage updates committed through an IDLE/COMMIT FSM, LRU training strobes.
// Define BTB_BYPASS_EN to forward a taken in-flight update to a matching lookup.
module btb_core
    import btb_pkg::*;
#(
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_hit,
    output logic             if_pred_taken,
    output logic [XLEN-1:0]  if_pred_target,
    output logic             branch1_used,
    output logic             branch2_used,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_taken,
    output logic [IDX_W-1:0] lru_update_index,
    input  logic             lru_victim,
    output logic             lru_new_entry
);

    btb_entry_t way1 [SETS];
    btb_entry_t way2 [SETS];

    btb_state_e      state;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] cap_target;
    logic            cap_taken;

    // Lookup side
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    btb_entry_t       l_w1, l_w2;
    logic             l_hit1, l_hit2;

    // Commit side
    logic [IDX_W-1:0] c_idx;
    logic [TAG_W-1:0] c_tag;
    btb_entry_t       c_w1, c_w2, c_new;
    logic             c_hit1, c_hit2, c_hit, c_sel_w2, c_write;
    logic [1:0]       c_cur_ctr, c_next_ctr;

    // The two low PC bits are never part of index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], cap_pc[1:0]};

    assign l_idx  = idx_of(if_pc);
    assign l_tag  = tag_of(if_pc);
    assign l_w1   = way1[l_idx];
    assign l_w2   = way2[l_idx];
    assign l_hit1 = l_w1.valid && (l_w1.tag == l_tag);
    assign l_hit2 = l_w2.valid && (l_w2.tag == l_tag);

    assign c_idx  = idx_of(cap_pc);
    assign c_tag  = tag_of(cap_pc);
    assign c_w1   = way1[c_idx];
    assign c_w2   = way2[c_idx];
    assign c_hit1 = c_w1.valid && (c_w1.tag == c_tag);
    assign c_hit2 = c_w2.valid && (c_w2.tag == c_tag);
    assign c_hit  = c_hit1 || c_hit2;

    // Choose the way to write: a hit way (way1 first), else the first free way, else the LRU victim.
    always_comb begin
        c_sel_w2 = 1'b0;
        if (c_hit1)             c_sel_w2 = 1'b0;
        else if (c_hit2)        c_sel_w2 = 1'b1;
        else if (!c_w1.valid)   c_sel_w2 = 1'b0;
        else if (!c_w2.valid)   c_sel_w2 = 1'b1;
        else                    c_sel_w2 = ~lru_victim;
    end

    assign c_cur_ctr = c_sel_w2 ? c_w2.ctr : c_w1.ctr;

    btb_sat_ctr u_sat_ctr (
        .ctr  (c_cur_ctr),
        .up   (cap_taken),
        .next (c_next_ctr)
    );

    // Build the entry to store: train an existing entry on a hit, allocate a fresh one on a taken miss.
    always_comb begin
        c_new = c_sel_w2 ? c_w2 : c_w1;
        if (c_hit) begin
            c_new.ctr = c_next_ctr;
            if (cap_taken) c_new.target = cap_target;
        end else begin
            c_new.valid  = 1'b1;
            c_new.tag    = c_tag;
            c_new.target = cap_target;
            c_new.ctr    = CTR_INIT;
        end
    end

    assign c_write          = (state == COMMIT) && (c_hit || cap_taken);
    assign lru_new_entry    = (state == COMMIT) && !c_hit && cap_taken;
    assign lru_update_index = (state == COMMIT) ? c_idx : l_idx;

    // Array storage: cleared on reset, written once at the end of a COMMIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                way1[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
                way2[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (c_write) begin
            if (c_sel_w2) way2[c_idx] <= c_new;
            else          way1[c_idx] <= c_new;
        end
    end

    // Update FSM: capture an offered branch in IDLE, spend one cycle committing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            upd_ready  <= 1'b1;
            cap_pc     <= '0;
            cap_target <= '0;
            cap_taken  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (upd_valid) begin
                        cap_pc     <= upd_pc;
                        cap_target <= upd_target;
                        cap_taken  <= upd_taken;
                        state      <= COMMIT;
                        upd_ready  <= 1'b0;
                    end
                end
                COMMIT: begin
                    state     <= IDLE;
                    upd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    upd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Combinational lookup with way1 priority, optionally forwarding a taken in-flight update.
    always_comb begin
        if_hit         = 1'b0;
        if_pred_taken  = 1'b0;
        if_pred_target = '0;
        branch1_used   = 1'b0;
        branch2_used   = 1'b0;
        if (if_valid) begin
            if (l_hit1) begin
                if_hit         = 1'b1;
                if_pred_taken  = l_w1.ctr[1];
                if_pred_target = l_w1.target;
                branch1_used   = 1'b1;
            end else if (l_hit2) begin
                if_hit         = 1'b1;
                if_pred_taken  = l_w2.ctr[1];
                if_pred_target = l_w2.target;
                branch2_used   = 1'b1;
            end
`ifdef BTB_BYPASS_EN
            if ((state == COMMIT) && cap_taken && (if_pc == cap_pc)) begin
                if_hit         = 1'b1;
                if_pred_taken  = 1'b1;
                if_pred_target = cap_target;
                branch1_used   = !c_sel_w2;
                branch2_used   = c_sel_w2;
            end
`endif
        end
    end

endmodule

// File: tb/tb_btb_core.sv
// Self-checking bench for btb_core against a per-set, per-way behavioural model.
module tb_btb_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_hit, if_pred_taken;
    logic [31:0] if_pred_target;
    logic        branch1_used, branch2_used;
    logic        upd_valid, upd_ready;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken;
    logic [2:0]  lru_update_index;
    logic        lru_victim, lru_new_entry;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ra, rc, ne;
        logic [2:0]  ix;
        logic        hit, pt;
        logic [31:0] tg;
        logic        b1, b2;
    } obs_t;

    // Behavioural model: per set, two ways (index 0 = way1, 1 = way2)
    bit          m_valid [8][2];
    logic [26:0] m_tag   [8][2];
    logic [31:0] m_tgt   [8][2];
    int          m_ctr   [8][2];

    btb_core dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc),
        .if_hit(if_hit), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .branch1_used(branch1_used), .branch2_used(branch2_used),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .lru_update_index(lru_update_index), .lru_victim(lru_victim),
        .lru_new_entry(lru_new_entry)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) % 8);
    endfunction

    function automatic logic [26:0] tag_from(input logic [31:0] pc);
        return 27'(pc >> 5);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0; m_tag[s][w] = '0; m_tgt[s][w] = '0; m_ctr[s][w] = 1;
            end
    endtask

    function automatic int model_find(input logic [31:0] pc);
        int s = set_of(pc);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_from(pc)) return w;
        return -1;
    endfunction

    function automatic int model_way(input logic [31:0] pc, input logic vic);
        int s = set_of(pc);
        int f = model_find(pc);
        if (f >= 0) return f;
        if (!m_valid[s][0]) return 0;
        if (!m_valid[s][1]) return 1;
        return vic ? 0 : 1;
    endfunction

    task automatic model_update(input logic [31:0] pc, tg, input logic tk, vic, output logic alloc);
        int s = set_of(pc);
        int f = model_find(pc);
        int w;
        alloc = 1'b0;
        if (f >= 0) begin
            if (tk) begin
                m_ctr[s][f] = (m_ctr[s][f] < 3) ? m_ctr[s][f] + 1 : 3;
                m_tgt[s][f] = tg;
            end else begin
                m_ctr[s][f] = (m_ctr[s][f] > 0) ? m_ctr[s][f] - 1 : 0;
            end
        end else if (tk) begin
            w = model_way(pc, vic);
            m_valid[s][w] = 1'b1; m_tag[s][w] = tag_from(pc); m_tgt[s][w] = tg; m_ctr[s][w] = 2;
            alloc = 1'b1;
        end
    endtask

    task automatic model_lookup(input logic [31:0] pc, input logic v,
                                output logic hit, pt, output logic [31:0] tg, output logic b1, b2);
        int f = model_find(pc);
        hit = 0; pt = 0; tg = '0; b1 = 0; b2 = 0;
        if (v && f >= 0) begin
            hit = 1; pt = (m_ctr[set_of(pc)][f] >= 2); tg = m_tgt[set_of(pc)][f];
            b1 = (f == 0); b2 = (f == 1);
        end
    endtask

    // Offer one update, observe accept and commit cycles (with a lookup of lpc during COMMIT),
    // and return the model's expectations alongside.
    task automatic do_update(input logic [31:0] pc, tg, input logic tk, vic, input logic [31:0] lpc,
                             output obs_t o, output obs_t e);
        logic alloc;
        @(negedge clk);
        upd_pc = pc; upd_target = tg; upd_taken = tk; lru_victim = vic; upd_valid = 1'b1;
        #1 o.ra = upd_ready;
        @(posedge clk);
        #1 upd_valid = 1'b0; if_valid = 1'b1; if_pc = lpc;
        @(negedge clk);
        o.rc = upd_ready; o.ne = lru_new_entry; o.ix = lru_update_index;
        o.hit = if_hit; o.pt = if_pred_taken; o.tg = if_pred_target; o.b1 = branch1_used; o.b2 = branch2_used;
        e.ra = 1'b1; e.rc = 1'b0; e.ix = 3'(set_of(pc));
        model_lookup(lpc, 1'b1, e.hit, e.pt, e.tg, e.b1, e.b2);
`ifdef BTB_BYPASS_EN
        if (lpc == pc && tk) begin
            int w = model_way(pc, vic);
            e.hit = 1; e.pt = 1; e.tg = tg; e.b1 = (w == 0); e.b2 = (w == 1);
        end
`endif
        model_update(pc, tg, tk, vic, alloc);
        e.ne = alloc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b1; if_pc = 32'h100;
        upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; lru_victim = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        total++; if (if_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit: got %b want 0", if_hit); end
        total++; if (branch1_used !== 1'b0 || branch2_used !== 1'b0) begin bad++; $display("[TB] FAIL reset_used: got %b%b want 00", branch1_used, branch2_used); end
        total++; if (upd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", upd_ready); end
        total++; if (lru_new_entry !== 1'b0) begin bad++; $display("[TB] FAIL reset_new_entry: got %b want 0", lru_new_entry); end
        total++; if (if_pred_target !== 32'h0 || if_pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL reset_pred: got %h/%b want 0/0", if_pred_target, if_pred_taken); end
        total++; if (lru_update_index !== 3'd0) begin bad++; $display("[TB] FAIL reset_index: got %0d want 0", lru_update_index); end
    endtask

    task automatic test_allocate();
        obs_t o, e;
        do_update(32'h100, 32'h200, 1'b1, 1'b0, 32'h100, o, e);
        total++; if (o.ra !== 1'b1) begin bad++; $display("[TB] FAIL alloc_accept_ready: got %b want 1", o.ra); end
        total++; if (o.rc !== 1'b0) begin bad++; $display("[TB] FAIL alloc_commit_ready: got %b want 0", o.rc); end
        total++; if (o.ne !== 1'b1) begin bad++; $display("[TB] FAIL alloc_new_entry: got %b want 1", o.ne); end
        total++; if (o.ix !== 3'd0) begin bad++; $display("[TB] FAIL alloc_index: got %0d want 0", o.ix); end
        total++; if (o.hit !== e.hit) begin bad++; $display("[TB] FAIL alloc_commit_lookup: got %b want %b", o.hit, e.hit); end
        if_valid = 1'b1; if_pc = 32'h100; #1;
        total++; if (if_hit !== 1'b1) begin bad++; $display("[TB] FAIL alloc_hit: got %b want 1", if_hit); end
        total++; if (if_pred_target !== 32'h200) begin bad++; $display("[TB] FAIL alloc_target: got %h want 200", if_pred_target); end
        total++; if (if_pred_taken !== 1'b1) begin bad++; $display("[TB] FAIL alloc_taken: got %b want 1", if_pred_taken); end
        total++; if (branch1_used !== 1'b1 || branch2_used !== 1'b0) begin bad++; $display("[TB] FAIL alloc_used: got %b%b want 10", branch1_used, branch2_used); end
        if_valid = 1'b0; #1;
        total++; if (if_hit !== 1'b0 || branch1_used !== 1'b0) begin bad++; $display("[TB] FAIL gated_lookup: got %b%b want 00", if_hit, branch1_used); end
    endtask

    task automatic test_replace();
        obs_t o, e;
        do_update(32'h120, 32'h320, 1'b1, 1'b0, 32'h0, o, e);
        total++; if (o.ne !== 1'b1) begin bad++; $display("[TB] FAIL fill_way2_new_entry: got %b want 1", o.ne); end
        do_update(32'h140, 32'h340, 1'b1, 1'b0, 32'h0, o, e);
        total++; if (o.ne !== 1'b1) begin bad++; $display("[TB] FAIL replace_new_entry: got %b want 1", o.ne); end
        if_valid = 1'b1; if_pc = 32'h120; #1;
        total++; if (if_hit !== 1'b0) begin bad++; $display("[TB] FAIL replaced_miss: got %b want 0", if_hit); end
        if_pc = 32'h140; #1;
        total++; if (if_hit !== 1'b1 || branch2_used !== 1'b1 || branch1_used !== 1'b0) begin bad++; $display("[TB] FAIL replace_way2: got hit=%b used=%b%b want 1 01", if_hit, branch1_used, branch2_used); end
        total++; if (if_pred_target !== 32'h340) begin bad++; $display("[TB] FAIL replace_target: got %h want 340", if_pred_target); end
        if_pc = 32'h100; #1;
        total++; if (branch1_used !== 1'b1 || if_pred_target !== 32'h200) begin bad++; $display("[TB] FAIL way1_kept: got %b/%h want 1/200", branch1_used, if_pred_target); end
    endtask

    task automatic test_saturate();
        obs_t o, e;
        for (int i = 0; i < 4; i++) begin
            do_update(32'h100, 32'hBAD0, 1'b0, 1'b0, 32'h0, o, e);
            total++; if (o.ne !== 1'b0) begin bad++; $display("[TB] FAIL sat_new_entry_%0d: got %b want 0", i, o.ne); end
        end
        if_valid = 1'b1; if_pc = 32'h100; #1;
        total++; if (if_hit !== 1'b1 || if_pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL sat_low: got hit=%b taken=%b want 1 0", if_hit, if_pred_taken); end
        total++; if (if_pred_target !== 32'h200) begin bad++; $display("[TB] FAIL sat_target_kept: got %h want 200", if_pred_target); end
        do_update(32'h100, 32'h260, 1'b1, 1'b0, 32'h0, o, e);
        if_valid = 1'b1; if_pc = 32'h100; #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL sat_no_wrap: got %b want 0", if_pred_taken); end
        total++; if (if_pred_target !== 32'h260) begin bad++; $display("[TB] FAIL taken_target_update: got %h want 260", if_pred_target); end
    endtask

    task automatic test_no_alloc();
        obs_t o, e;
        do_update(32'h300, 32'h900, 1'b0, 1'b1, 32'h0, o, e);
        total++; if (o.ne !== 1'b0) begin bad++; $display("[TB] FAIL noalloc_new_entry: got %b want 0", o.ne); end
        if_valid = 1'b1; if_pc = 32'h300; #1;
        total++; if (if_hit !== 1'b0) begin bad++; $display("[TB] FAIL noalloc_miss: got %b want 0", if_hit); end
        if_pc = 32'h140; #1;
        total++; if (if_pred_target !== 32'h340) begin bad++; $display("[TB] FAIL noalloc_way2_kept: got %h want 340", if_pred_target); end
    endtask

    task automatic test_commit_visibility();
        obs_t o, e;
        logic [31:0] want_tg;
`ifdef BTB_BYPASS_EN
        want_tg = 32'h440;
`else
        want_tg = 32'h340;
`endif
        do_update(32'h140, 32'h440, 1'b1, 1'b0, 32'h140, o, e);
        total++; if (o.hit !== 1'b1 || o.b2 !== 1'b1) begin bad++; $display("[TB] FAIL commit_lookup_hit: got %b/%b want 1/1", o.hit, o.b2); end
        total++; if (o.tg !== want_tg) begin bad++; $display("[TB] FAIL commit_lookup_target: got %h want %h", o.tg, want_tg); end
        if_valid = 1'b1; if_pc = 32'h140; #1;
        total++; if (if_pred_target !== 32'h440) begin bad++; $display("[TB] FAIL post_commit_target: got %h want 440", if_pred_target); end
    endtask

    task automatic test_back_to_back();
        logic alloc;
        logic exp_ready [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic exp_ne    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        upd_pc = 32'h504; upd_target = 32'h604; upd_taken = 1'b1; lru_victim = 1'b0; upd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (upd_ready !== exp_ready[k]) begin bad++; $display("[TB] FAIL b2b_ready_%0d: got %b want %b", k, upd_ready, exp_ready[k]); end
            total++; if (lru_new_entry !== exp_ne[k]) begin bad++; $display("[TB] FAIL b2b_new_entry_%0d: got %b want %b", k, lru_new_entry, exp_ne[k]); end
            if (k == 3) upd_valid = 1'b0;
            @(negedge clk);
        end
        model_update(32'h504, 32'h604, 1'b1, 1'b0, alloc);
        model_update(32'h504, 32'h604, 1'b1, 1'b0, alloc);
        if_valid = 1'b1; if_pc = 32'h504; #1;
        total++; if (if_hit !== 1'b1 || if_pred_taken !== 1'b1 || if_pred_target !== 32'h604) begin bad++; $display("[TB] FAIL b2b_lookup: got %b/%b/%h want 1/1/604", if_hit, if_pred_taken, if_pred_target); end
    endtask

    task automatic test_reset_commit();
        @(negedge clk);
        upd_pc = 32'h408; upd_target = 32'h7770; upd_taken = 1'b1; lru_victim = 1'b0; upd_valid = 1'b1;
        @(posedge clk);
        #1 upd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (upd_ready !== 1'b1 || lru_new_entry !== 1'b0) begin bad++; $display("[TB] FAIL rst_commit_outputs: got %b/%b want 1/0", upd_ready, lru_new_entry); end
        @(negedge clk) rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        if_valid = 1'b1; if_pc = 32'h408; #1;
        total++; if (if_hit !== 1'b0) begin bad++; $display("[TB] FAIL rst_commit_dropped: got %b want 0", if_hit); end
        total++; if (upd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_commit_ready: got %b want 1", upd_ready); end
        if_pc = 32'h100; #1;
        total++; if (if_hit !== 1'b0) begin bad++; $display("[TB] FAIL rst_clears_array: got %b want 0", if_hit); end
    endtask

    function automatic logic [31:0] rand_pc();
        return ((($urandom % 3) + 1) << 5) | (($urandom % 8) << 2);
    endfunction

    task automatic test_random();
        obs_t o, e;
        logic [31:0] pc, lpc;
        logic eh, ep, e1, e2;
        logic [31:0] et;
        for (int i = 0; i < 80; i++) begin
            pc  = rand_pc();
            lpc = ($urandom % 2 == 0) ? pc : rand_pc();
            do_update(pc, {$urandom} & 32'hFFFF_FFFC, 1'($urandom % 4 != 0), 1'($urandom), lpc, o, e);
            total++; if (o.ra !== e.ra || o.rc !== e.rc) begin bad++; $display("[TB] FAIL rnd_ready_%0d: got %b%b want %b%b", i, o.ra, o.rc, e.ra, e.rc); end
            total++; if (o.ne !== e.ne) begin bad++; $display("[TB] FAIL rnd_new_entry_%0d: got %b want %b", i, o.ne, e.ne); end
            total++; if (o.ix !== e.ix) begin bad++; $display("[TB] FAIL rnd_index_%0d: got %0d want %0d", i, o.ix, e.ix); end
            total++; if ({o.hit, o.pt, o.b1, o.b2, o.tg} !== {e.hit, e.pt, e.b1, e.b2, e.tg}) begin bad++; $display("[TB] FAIL rnd_commit_lookup_%0d: got %b%b%b%b %h want %b%b%b%b %h", i, o.hit, o.pt, o.b1, o.b2, o.tg, e.hit, e.pt, e.b1, e.b2, e.tg); end
            if_valid = 1'($urandom % 8 != 0); if_pc = rand_pc(); #1;
            model_lookup(if_pc, if_valid, eh, ep, et, e1, e2);
            total++; if ({if_hit, if_pred_taken, branch1_used, branch2_used, if_pred_target} !== {eh, ep, e1, e2, et}) begin bad++; $display("[TB] FAIL rnd_lookup_%0d: got %b%b%b%b %h want %b%b%b%b %h", i, if_hit, if_pred_taken, branch1_used, branch2_used, if_pred_target, eh, ep, e1, e2, et); end
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_replace();
        test_saturate();
        test_no_alloc();
        test_commit_visibility();
        test_back_to_back();
        test_reset_commit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
